alu_issue_unit: RTL and testbench

Sequential front end that sits between the decode stage and the 32-bit ALU. It accepts an operation request (main-control ALU op class, funct field, two operands) over a valid/ready handshake and decodes it to the 4-bit ALU operation code. It drives the ALU from stable registers, captures `ALUResult`/`Zero`, and returns them over a second valid/ready handshake. An optional built-in iterative squarer removes the wide combinational multiply from the ALU critical path.

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 36 +++
 rtl/alu_issue_unit.sv | 132 +++++++++++++
 tb/tb_alu_issue_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue front end: ALU operation codes, main-control
// op classes, R-type funct values and the issue FSM state encoding.
package alu_issue_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_SQU     = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_MOV     = 4'b1111;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1110;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SQU = 6'h18;
  localparam logic [5:0] FN_MOV = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2,
    ST_MULT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: main-control op class plus funct field to the 4-bit
// ALU operation code, with an illegal flag for anything that does not decode.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       illegal
);

  // Anything that falls through the decode drives the code the ALU answers with 0.
  always_comb begin
    alu_operation = ALU_ILLEGAL;
    illegal       = 1'b1;
    case (alu_op)
      OP_ADD: begin alu_operation = ALU_ADD; illegal = 1'b0; end
      OP_SUB: begin alu_operation = ALU_SUB; illegal = 1'b0; end
      OP_AND: begin alu_operation = ALU_AND; illegal = 1'b0; end
      OP_NOR: begin alu_operation = ALU_NOR; illegal = 1'b0; end
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_operation = ALU_ADD; illegal = 1'b0; end
          FN_SUB: begin alu_operation = ALU_SUB; illegal = 1'b0; end
          FN_AND: begin alu_operation = ALU_AND; illegal = 1'b0; end
          FN_NOR: begin alu_operation = ALU_NOR; illegal = 1'b0; end
          FN_SQU: begin alu_operation = ALU_SQU; illegal = 1'b0; end
          FN_MOV: begin alu_operation = ALU_MOV; illegal = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end between decode and the 32-bit ALU: request/response handshakes,
// registered ALU drive and result capture. Define ALU_ISSUE_ITER_SQU_EN for the iterative squarer.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic [3:0]        ALUOperation,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              Zero
);

  state_t     state, state_nxt;
  logic [3:0] dec_op;
  logic       dec_illegal;
  logic       accept;
  logic       start_mult;
  logic       illegal_q;
  state_t     start_state;

  alu_ctrl_decode u_decode (
    .alu_op       (alu_op),
    .funct        (funct),
    .alu_operation(dec_op),
    .illegal      (dec_illegal)
  );

  assign req_ready   = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
  assign rsp_valid   = (state == ST_RESP);
  assign accept      = req_valid && req_ready;
  assign start_state = start_mult ? ST_MULT : ST_EXEC;

`ifdef ALU_ISSUE_ITER_SQU_EN
  logic [5:0]        mult_cnt;
  logic [DATA_W-1:0] mult_acc, mult_acc_nxt;
  logic              mult_last;

  assign start_mult = (dec_op == ALU_SQU);
  assign mult_last  = (mult_cnt == 6'd31);

  // One partial product of A*A per cycle; only the low DATA_W bits are kept.
  always_comb begin
    mult_acc_nxt = mult_acc;
    if (A[mult_cnt[4:0]])
      mult_acc_nxt = mult_acc + (A << mult_cnt[4:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_cnt <= '0;
      mult_acc <= '0;
    end else if (accept) begin
      mult_cnt <= '0;
      mult_acc <= '0;
    end else if (state == ST_MULT) begin
      mult_cnt <= mult_cnt + 6'd1;
      mult_acc <= mult_acc_nxt;
    end
  end
`else
  assign start_mult = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = start_state;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = accept ? start_state : ST_IDLE;
`ifdef ALU_ISSUE_ITER_SQU_EN
      ST_MULT: if (mult_last) state_nxt = ST_RESP;
`else
      ST_MULT: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU drive changes only on acceptance; a squarer request leaves the op code alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOperation <= '0;
      A            <= '0;
      B            <= '0;
      illegal_q    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      if (accept) begin
        A         <= rs_data;
        B         <= rt_data;
        illegal_q <= dec_illegal;
        if (!start_mult)
          ALUOperation <= dec_op;
      end
      if (state == ST_EXEC) begin
        rsp_result  <= ALUResult;
        rsp_zero    <= Zero;
        rsp_illegal <= illegal_q;
      end
`ifdef ALU_ISSUE_ITER_SQU_EN
      if ((state == ST_MULT) && mult_last) begin
        rsp_result  <= mult_acc_nxt;
        rsp_zero    <= (mult_acc_nxt == '0);
        rsp_illegal <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed vector table, backpressure and
// reset sequences, then randomized requests against a behavioural reference model.
module tb_alu_issue_unit;

  typedef struct {
    string       name;
    logic [2:0]  cls;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  op;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [31:0] ALUResult;
  logic        Zero;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  lastOp;
  logic [5:0]  fnList [6];
  vec_t        vecs [10];

`ifdef ALU_ISSUE_ITER_SQU_EN
  localparam int SQU_LAT  = 33;
  localparam bit SQU_HOLD = 1'b1;
`else
  localparam int SQU_LAT  = 2;
  localparam bit SQU_HOLD = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .alu_op(alu_op), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .ALUOperation(ALUOperation), .A(A), .B(B),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  // Stand-in for the external 32-bit ALU.
  always_comb begin
    case (ALUOperation)
      4'b0000: ALUResult = A & B;
      4'b0001: ALUResult = A * A;
      4'b0010: ALUResult = ~(A | B);
      4'b0011: ALUResult = A + B;
      4'b0110: ALUResult = A - B;
      4'b1111: ALUResult = (A == B) ? 32'd1 : 32'd0;
      default: ALUResult = 32'd0;
    endcase
  end
  assign Zero = (ALUResult == 32'd0);

  function automatic vec_t mkVec(input string name, input logic [2:0] cls, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                 input logic zero, input logic ill, input logic [3:0] op, input int lat);
    vec_t v;
    v.name = name; v.cls = cls; v.fn = fn; v.a = a; v.b = b;
    v.res = res; v.zero = zero; v.ill = ill; v.op = op; v.lat = lat;
    return v;
  endfunction

  function automatic string mnemonic(input logic [2:0] cls, input logic [5:0] fn);
    if (cls == 3'd0) return "ADD";
    if (cls == 3'd1) return "SUB";
    if (cls == 3'd3) return "AND";
    if (cls == 3'd4) return "NOR";
    if (cls == 3'd2) begin
      if (fn == 6'h20) return "ADD";
      if (fn == 6'h22) return "SUB";
      if (fn == 6'h24) return "AND";
      if (fn == 6'h27) return "NOR";
      if (fn == 6'h18) return "SQU";
      if (fn == 6'h2A) return "MOV";
    end
    return "ILL";
  endfunction

  // Reference model: what the whole transaction should return, from the operation's meaning.
  function automatic vec_t refModel(input logic [2:0] cls, input logic [5:0] fn,
                                    input logic [31:0] a, input logic [31:0] b, input logic [3:0] prevOp);
    vec_t        v;
    string       m;
    logic [63:0] sq;
    m = mnemonic(cls, fn);
    v = mkVec({"rnd_", m}, cls, fn, a, b, 32'd0, 1'b1, 1'b0, 4'b1110, 2);
    case (m)
      "ADD": begin v.res = a + b;    v.op = 4'b0011; end
      "SUB": begin v.res = a - b;    v.op = 4'b0110; end
      "AND": begin v.res = a & b;    v.op = 4'b0000; end
      "NOR": begin v.res = ~(a | b); v.op = 4'b0010; end
      "MOV": begin v.res = (a == b) ? 32'd1 : 32'd0; v.op = 4'b1111; end
      "SQU": begin
        sq     = {32'd0, a} * {32'd0, a};
        v.res  = sq[31:0];
        v.op   = SQU_HOLD ? prevOp : 4'b0001;
        v.lat  = SQU_LAT;
      end
      default: v.ill = 1'b1;
    endcase
    v.zero = (v.res == 32'd0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({name, "_rsp_result"}, rsp_result, 32'd0);
    checkOutput({name, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
    checkOutput({name, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
    checkOutput({name, "_aluop"}, {28'd0, ALUOperation}, 32'd0);
    checkOutput({name, "_A"}, A, 32'd0);
    checkOutput({name, "_B"}, B, 32'd0);
  endtask

  // Presents a request and returns just after the posedge on which it was accepted.
  task automatic applyStimulus(input vec_t v);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    alu_op = v.cls; funct = v.fn; rs_data = v.a; rt_data = v.b; req_valid = 1'b1;
    while (!req_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({v.name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic runTxn(input vec_t v, input int hold);
    int lat;
    applyStimulus(v);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 1'b0;
    end while (!rsp_valid && lat < 100);
    checkOutput({v.name, "_latency"}, lat, v.lat);
    repeat (hold) @(negedge clk);
    checkOutput({v.name, "_result"}, rsp_result, v.res);
    checkOutput({v.name, "_zero"}, {31'd0, rsp_zero}, {31'd0, v.zero});
    checkOutput({v.name, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, v.ill});
    checkOutput({v.name, "_aluop"}, {28'd0, ALUOperation}, {28'd0, v.op});
    checkOutput({v.name, "_A"}, A, v.a);
    checkOutput({v.name, "_B"}, B, v.b);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({v.name, "_drop"}, {31'd0, rsp_valid}, 32'd0);
    lastOp = v.op;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    vec_t        v;
    logic [2:0]  cls;
    logic [5:0]  fn;
    logic [31:0] a, b;

    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    alu_op = '0; funct = '0; rs_data = '0; rt_data = '0;
    lastOp = 4'b0000;
    fnList = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h18, 6'h2A};

    vecs[0] = mkVec("add",     3'b010, 6'h20, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 4'b0011, 2);
    vecs[1] = mkVec("sub_eq",  3'b001, 6'h00, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 4'b0110, 2);
    vecs[2] = mkVec("mov_eq",  3'b010, 6'h2A, 32'h1234,     32'h1234,     32'd1,        1'b0, 1'b0, 4'b1111, 2);
    vecs[3] = mkVec("ill_op",  3'b101, 6'h20, 32'd3,        32'd4,        32'd0,        1'b1, 1'b1, 4'b1110, 2);
    vecs[4] = mkVec("and",     3'b011, 6'h00, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0, 1'b0, 4'b0000, 2);
    vecs[5] = mkVec("nor",     3'b100, 6'h00, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0, 1'b0, 4'b0010, 2);
    vecs[6] = mkVec("squ",     3'b010, 6'h18, 32'h00010001, 32'h55,       32'h00020001, 1'b0, 1'b0,
                    SQU_HOLD ? 4'b0010 : 4'b0001, SQU_LAT);
    vecs[7] = mkVec("ill_fn",  3'b010, 6'h3F, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1, 4'b1110, 2);
    vecs[8] = mkVec("sub_neg", 3'b001, 6'h00, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 4'b0110, 2);
    vecs[9] = mkVec("rsub_eq", 3'b010, 6'h22, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 4'b0110, 2);

    repeat (2) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) runTxn(vecs[i], i % 3);

    // Backpressure: response held five cycles with a second request waiting.
    v = mkVec("bp_first", 3'b000, 6'h00, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 4'b0011, 2);
    applyStimulus(v);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
    alu_op = 3'b001; rs_data = 32'd50; rt_data = 32'd8; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_hold_result", rsp_result, 32'd123);
      checkOutput("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("bp_hold_A", A, 32'd100);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    checkOutput("bp_exec_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_exec_aluop", {28'd0, ALUOperation}, 32'h6);
    checkOutput("bp_exec_A", A, 32'd50);
    @(negedge clk);
    checkOutput("bp_second_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("bp_second_result", rsp_result, 32'd42);
    checkOutput("bp_second_zero", {31'd0, rsp_zero}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_second_drop", {31'd0, rsp_valid}, 32'd0);
    lastOp = 4'b0110;

    // Reset pulse while the request is executing.
    v = mkVec("rst_exec_req", 3'b000, 6'h00, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 4'b0011, 2);
    applyStimulus(v);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkReset("rst_exec");
    @(negedge clk);
    reset = 1'b0;
    lastOp = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    runTxn(mkVec("after_rst_exec", 3'b000, 6'h00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 4'b0011, 2), 0);

    // Reset pulse a few cycles into a square (mid-multiply when the squarer is built in).
    v = mkVec("rst_squ_req", 3'b010, 6'h18, 32'h00010001, 32'd0, 32'h00020001, 1'b0, 1'b0, 4'b0001, SQU_LAT);
    applyStimulus(v);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkReset("rst_squ");
    @(negedge clk);
    reset = 1'b0;
    lastOp = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("rst_squ_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    runTxn(mkVec("squ_wrap", 3'b010, 6'h18, 32'h00030000, 32'd7, 32'd0, 1'b1, 1'b0,
                 SQU_HOLD ? 4'b0000 : 4'b0001, SQU_LAT), 1);

    // Randomized requests against the reference model.
    for (int i = 0; i < 30; i++) begin
      cls = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = fnList[$urandom_range(0, 5)];
      a = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      else                           b = $urandom;
      v = refModel(cls, fn, a, b, lastOp);
      runTxn(v, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
